// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone-style arbiter in front of the unified instruction/data RAM.
// m0 is the read-only fetch port, m1 the load/store port; one transfer is in flight at a time.
module wb_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RR_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] m0_adr,
  input  logic              m0_stb,
  output logic [DATA_W-1:0] m0_dat_o,
  output logic              m0_ack,
  input  logic [ADDR_W-1:0] m1_adr,
  input  logic [DATA_W-1:0] m1_dat_i,
  input  logic              m1_we,
  input  logic              m1_stb,
  output logic [DATA_W-1:0] m1_dat_o,
  output logic              m1_ack,
  output logic [ADDR_W-1:0] s_adr,
  output logic [DATA_W-1:0] s_dat_o,
  output logic              s_we,
  output logic              s_stb,
  input  logic [DATA_W-1:0] s_dat_i,
  input  logic              s_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic              grant_reg;   // 0 = m0, 1 = m1
  logic              last_reg;    // master served by the most recent completed transfer
  logic [ADDR_W-1:0] adr_reg;
  logic [DATA_W-1:0] dat_reg;
  logic              we_reg;
  logic [DATA_W-1:0] m0_rdata_reg, m1_rdata_reg;
  logic              any_req;
  logic              winner;

  assign any_req = m0_stb | m1_stb;

  // On a tie, round-robin hands the bus to whoever did not have it last.
  always_comb begin
    winner = m1_stb;
    if (m0_stb && m1_stb) begin
      winner = (RR_MODE != 0) ? ~last_reg : 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (any_req) state_next = BUS;
      BUS:     if (s_ack) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, read-data capture and round-robin history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_reg    <= 1'b0;
      last_reg     <= 1'b0;
      adr_reg      <= '0;
      dat_reg      <= '0;
      we_reg       <= 1'b0;
      m0_rdata_reg <= '0;
      m1_rdata_reg <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (any_req) begin
            grant_reg <= winner;
            adr_reg   <= winner ? m1_adr : m0_adr;
            dat_reg   <= winner ? m1_dat_i : '0;
            we_reg    <= winner & m1_we;
          end
        end
        BUS: begin
          if (s_ack && !we_reg) begin
            if (grant_reg) begin
              m1_rdata_reg <= s_dat_i;
            end else begin
              m0_rdata_reg <= s_dat_i;
            end
          end
        end
        RESP: begin
          last_reg <= grant_reg;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    s_stb   = 1'b0;
    s_adr   = '0;
    s_dat_o = '0;
    s_we    = 1'b0;
    m0_ack  = 1'b0;
    m1_ack  = 1'b0;
    if (state_reg == BUS) begin
      s_stb   = 1'b1;
      s_adr   = adr_reg;
      s_dat_o = dat_reg;
      s_we    = we_reg;
    end
    if (state_reg == RESP) begin
      m0_ack = ~grant_reg;
      m1_ack = grant_reg;
    end
  end

  assign m0_dat_o = m0_rdata_reg;
  assign m1_dat_o = m1_rdata_reg;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Self-checking bench: one arbiter per arbitration mode, each in front of its own RAM,
// driven by shared master stimulus and compared with a transaction-schedule model.
module tb_wb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-1:0] m0_adr, m1_adr;
  logic [DW-1:0] m1_dat_i;
  logic          m0_stb, m1_stb, m1_we;
  logic          pre_we;
  logic [12:0]   pre_idx;
  logic [DW-1:0] pre_dat;

  logic [DW-1:0] m0_dat_o [2];
  logic [DW-1:0] m1_dat_o [2];
  logic          m0_ack   [2];
  logic          m1_ack   [2];
  logic [AW-1:0] s_adr    [2];
  logic [DW-1:0] s_dat_o  [2];
  logic [DW-1:0] s_dat_i  [2];
  logic          s_we     [2];
  logic          s_stb    [2];
  logic          s_ack    [2];

  int checks = 0;
  int errors = 0;

  // Index 0: fixed priority, index 1: round-robin.
  for (genvar gi = 0; gi < 2; gi++) begin : g_mode
    logic [DW-1:0] mem [0:8191];

    wb_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_MODE(gi)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_adr(m0_adr), .m0_stb(m0_stb), .m0_dat_o(m0_dat_o[gi]), .m0_ack(m0_ack[gi]),
      .m1_adr(m1_adr), .m1_dat_i(m1_dat_i), .m1_we(m1_we), .m1_stb(m1_stb),
      .m1_dat_o(m1_dat_o[gi]), .m1_ack(m1_ack[gi]),
      .s_adr(s_adr[gi]), .s_dat_o(s_dat_o[gi]), .s_we(s_we[gi]), .s_stb(s_stb[gi]),
      .s_dat_i(s_dat_i[gi]), .s_ack(s_ack[gi])
    );

    // RAM acks immediately; read data is presented alongside the ack.
    assign s_ack[gi]   = s_stb[gi];
    assign s_dat_i[gi] = mem[s_adr[gi][14:2]];
    always @(posedge clk) begin
      if (pre_we) mem[pre_idx] <= pre_dat;
      else if (s_stb[gi] && s_ack[gi] && s_we[gi]) mem[s_adr[gi][14:2]] <= s_dat_o[gi];
    end
  end

  // Reference model: a transfer granted at edge E strobes the RAM until E+1,
  // acks until E+2, and the arbiter can grant again at E+3.
  int            cyc = 0;
  int            t_edge [2];
  bit            t_act  [2];
  bit            t_who  [2];
  bit            t_last [2];
  bit            t_we   [2];
  logic [AW-1:0] t_adr  [2];
  logic [DW-1:0] t_dat  [2];
  logic [DW-1:0] e_d0   [2];
  logic [DW-1:0] e_d1   [2];
  logic [DW-1:0] ref_mem [2][0:8191];

  task automatic model_step();
    cyc++;
    for (int g = 0; g < 2; g++) begin
      if (pre_we) ref_mem[g][pre_idx] = pre_dat;
      if (t_act[g] && cyc == t_edge[g] + 1) begin
        if (t_we[g]) ref_mem[g][t_adr[g][14:2]] = t_dat[g];
        else if (rst_n && t_who[g]) e_d1[g] = ref_mem[g][t_adr[g][14:2]];
        else if (rst_n) e_d0[g] = ref_mem[g][t_adr[g][14:2]];
      end
      if (!rst_n) begin
        t_act[g] = 1'b0; t_last[g] = 1'b0; e_d0[g] = '0; e_d1[g] = '0;
      end else if (t_act[g] && cyc == t_edge[g] + 2) begin
        t_act[g] = 1'b0; t_last[g] = t_who[g];
      end else if (!t_act[g] && (m0_stb || m1_stb)) begin
        if (m0_stb && m1_stb) t_who[g] = (g == 1) ? !t_last[g] : 1'b1;
        else t_who[g] = m1_stb;
        t_adr[g]  = t_who[g] ? m1_adr : m0_adr;
        t_we[g]   = t_who[g] && m1_we;
        t_dat[g]  = m1_dat_i;
        t_act[g]  = 1'b1;
        t_edge[g] = cyc;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m0_stb = 1'b1; m1_stb = 1'b1; m1_we = 1'b0;
    m0_adr = '0; m1_adr = '0; m1_dat_i = '0;
    for (int i = 0; i < 64; i++) begin
      pre_we = 1'b1; pre_idx = 13'(i);
      pre_dat = (i == 4) ? 32'hDEAD_BEEF : $urandom;
      tick();
    end
    pre_we = 1'b0;
    tick(); tick();
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({s_stb[g], s_we[g], m0_ack[g], m1_ack[g]} !== 4'b0000) begin
        errors++; $display("FAIL reset_ctrl mode%0d: stb/we/ack0/ack1=%b required 0000", g,
                           {s_stb[g], s_we[g], m0_ack[g], m1_ack[g]});
      end
      checks++;
      if (s_adr[g] !== '0 || m0_dat_o[g] !== '0 || m1_dat_o[g] !== '0) begin
        errors++; $display("FAIL reset_data mode%0d: s_adr=%h m0_dat_o=%h m1_dat_o=%h required 0",
                           g, s_adr[g], m0_dat_o[g], m1_dat_o[g]);
      end
    end
    $display("reset: both masters requesting, all outputs idle");
    m0_stb = 1'b0; m1_stb = 1'b0; rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    m0_adr = 32'h0000_0010; m0_stb = 1'b1;
    tick();
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (s_stb[g] !== 1'b1 || s_adr[g] !== 32'h10 || s_we[g] !== 1'b0 || m0_ack[g] !== 1'b0) begin
        errors++; $display("FAIL fetch_bus mode%0d: stb=%b adr=%h we=%b ack=%b required 1/00000010/0/0",
                           g, s_stb[g], s_adr[g], s_we[g], m0_ack[g]);
      end
    end
    tick();
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (m0_ack[g] !== 1'b1 || m1_ack[g] !== 1'b0 || m0_dat_o[g] !== 32'hDEAD_BEEF || s_stb[g] !== 1'b0) begin
        errors++; $display("FAIL fetch_ack mode%0d: ack0=%b ack1=%b dat=%h stb=%b required 1/0/deadbeef/0",
                           g, m0_ack[g], m1_ack[g], m0_dat_o[g], s_stb[g]);
      end
    end
    $display("fetch: adr=00000010 -> m0_dat_o=%h", m0_dat_o[0]);
    m0_stb = 1'b0;
    tick();
    checks++;
    if (m0_ack[0] !== 1'b0) begin
      errors++; $display("FAIL fetch_single_pulse: m0_ack=%b required 0", m0_ack[0]);
    end
  endtask

  task automatic test_store_load();
    m1_adr = 32'h40; m1_dat_i = 32'h1234_5678; m1_we = 1'b1; m1_stb = 1'b1;
    tick();
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (s_stb[g] !== 1'b1 || s_we[g] !== 1'b1 || s_dat_o[g] !== 32'h1234_5678) begin
        errors++; $display("FAIL store_bus mode%0d: stb=%b we=%b dat=%h required 1/1/12345678",
                           g, s_stb[g], s_we[g], s_dat_o[g]);
      end
    end
    tick();
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (m1_ack[g] !== 1'b1 || m1_dat_o[g] !== 32'h0) begin
        errors++; $display("FAIL store_ack mode%0d: ack=%b dat_o=%h required 1/00000000",
                           g, m1_ack[g], m1_dat_o[g]);
      end
    end
    checks++;
    if (g_mode[0].mem[16] !== 32'h1234_5678 || g_mode[1].mem[16] !== 32'h1234_5678) begin
      errors++; $display("FAIL store_ram: word16=%h/%h required 12345678",
                         g_mode[0].mem[16], g_mode[1].mem[16]);
    end
    $display("store: 12345678 -> adr 00000040");
    m1_stb = 1'b0; m1_we = 1'b0;
    tick();
    m1_stb = 1'b1;
    tick(); tick();
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (m1_ack[g] !== 1'b1 || m0_ack[g] !== 1'b0 || m1_dat_o[g] !== 32'h1234_5678) begin
        errors++; $display("FAIL load_ack mode%0d: ack1=%b ack0=%b dat_o=%h required 1/0/12345678",
                           g, m1_ack[g], m0_ack[g], m1_dat_o[g]);
      end
    end
    $display("load: adr 00000040 -> m1_dat_o=%h", m1_dat_o[0]);
    m1_stb = 1'b0;
    tick();
  endtask

  // Both masters hold stb for 12 cycles after a reset; acks land on cycles 2,5,8,11.
  task automatic tie_run(input int g, input bit rr);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    m0_adr = 32'h10; m1_adr = 32'h40; m1_we = 1'b0; m0_stb = 1'b1; m1_stb = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      bit a0, a1;
      tick();
      a1 = (k % 3 == 2) && (!rr || ((k / 3) % 2 == 0));
      a0 = (k % 3 == 2) && !a1;
      checks++;
      if (m0_ack[g] !== a0 || m1_ack[g] !== a1) begin
        errors++; $display("FAIL tie_order mode%0d cyc%0d: ack0/ack1=%b%b required %b%b",
                           g, k, m0_ack[g], m1_ack[g], a0, a1);
      end
      if (a0 || a1) begin
        checks++;
        if ((a0 && m0_dat_o[g] !== 32'hDEAD_BEEF) || (a1 && m1_dat_o[g] !== 32'h1234_5678)) begin
          errors++; $display("FAIL tie_data mode%0d cyc%0d: m0=%h m1=%h", g, k, m0_dat_o[g], m1_dat_o[g]);
        end
        $display("tie mode%0d cycle %0d: ack to m%0d", g, k, a1 ? 1 : 0);
      end
    end
    m0_stb = 1'b0; m1_stb = 1'b0;
    tick(); tick();
  endtask

  task automatic test_fixed_priority();
    tie_run(0, 1'b0);
  endtask

  task automatic test_round_robin();
    tie_run(1, 1'b1);
  endtask

  task automatic test_reset_mid_transfer();
    m1_adr = 32'h40; m1_we = 1'b0; m1_stb = 1'b1;
    tick();
    checks++;
    if (s_stb[0] !== 1'b1) begin
      errors++; $display("FAIL abort_setup: s_stb=%b required 1", s_stb[0]);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; m1_stb = 1'b0;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (m1_ack[g] !== 1'b0 || s_stb[g] !== 1'b0 || m1_dat_o[g] !== '0) begin
        errors++; $display("FAIL abort mode%0d: ack=%b stb=%b dat_o=%h required 0/0/0",
                           g, m1_ack[g], s_stb[g], m1_dat_o[g]);
      end
    end
    tick();
    checks++;
    if (m1_ack[0] !== 1'b0 || m1_ack[1] !== 1'b0) begin
      errors++; $display("FAIL abort_late_ack: acks=%b%b required 00", m1_ack[0], m1_ack[1]);
    end
    m0_adr = 32'h10; m0_stb = 1'b1;
    tick(); tick();
    checks++;
    if (m0_ack[0] !== 1'b1 || m0_dat_o[0] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL abort_recover: ack=%b dat=%h required 1/deadbeef", m0_ack[0], m0_dat_o[0]);
    end
    $display("abort: read aborted by reset, next fetch served");
    m0_stb = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int fails_before = errors;
    for (int n = 0; n < 800; n++) begin
      m0_stb   = ($urandom_range(0, 3) != 0);
      m1_stb   = ($urandom_range(0, 2) != 0);
      m1_we    = $urandom_range(0, 1) == 1;
      m0_adr   = $urandom & 32'hFFFF_80FF;
      m1_adr   = $urandom & 32'hFFFF_80FF;
      m1_dat_i = $urandom;
      tick();
      for (int g = 0; g < 2; g++) begin
        bit es, ea0, ea1;
        es  = t_act[g] && (cyc == t_edge[g]);
        ea0 = t_act[g] && (cyc == t_edge[g] + 1) && !t_who[g];
        ea1 = t_act[g] && (cyc == t_edge[g] + 1) && t_who[g];
        checks++;
        if (s_stb[g] !== es || m0_ack[g] !== ea0 || m1_ack[g] !== ea1) begin
          errors++; $display("FAIL rand_ctrl mode%0d n%0d: stb/ack0/ack1=%b%b%b required %b%b%b",
                             g, n, s_stb[g], m0_ack[g], m1_ack[g], es, ea0, ea1);
        end
        checks++;
        if (m0_dat_o[g] !== e_d0[g] || m1_dat_o[g] !== e_d1[g]) begin
          errors++; $display("FAIL rand_data mode%0d n%0d: m0=%h m1=%h required %h %h",
                             g, n, m0_dat_o[g], m1_dat_o[g], e_d0[g], e_d1[g]);
        end
        if (es) begin
          checks++;
          if (s_adr[g] !== t_adr[g] || s_we[g] !== t_we[g] || (t_we[g] && s_dat_o[g] !== t_dat[g])) begin
            errors++; $display("FAIL rand_bus mode%0d n%0d: adr=%h we=%b dat=%h required %h %b %h",
                               g, n, s_adr[g], s_we[g], s_dat_o[g], t_adr[g], t_we[g], t_dat[g]);
          end
          $display("rand mode%0d n%0d: grant m%0d adr=%h we=%b", g, n, t_who[g] ? 1 : 0, t_adr[g], t_we[g]);
        end
      end
    end
    $display("random: %0d new errors", errors - fails_before);
    m0_stb = 1'b0; m1_stb = 1'b0;
    tick(); tick(); tick();
  endtask

  initial begin
    pre_we = 1'b0; pre_idx = '0; pre_dat = '0;
    for (int g = 0; g < 2; g++) begin
      t_act[g] = 1'b0; t_last[g] = 1'b0; t_edge[g] = 0; t_who[g] = 1'b0;
      t_we[g] = 1'b0; t_adr[g] = '0; t_dat[g] = '0; e_d0[g] = '0; e_d1[g] = '0;
    end
    test_reset();
    test_fetch();
    test_store_load();
    test_fixed_priority();
    test_round_robin();
    test_reset_mid_transfer();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
